bcd_digit_counter: RTL and testbench
====================================

Name: bcd_digit_counter

Overview:
Parametrised synchronous single-digit counter for the irrigation clock/timer chain. It replaces the fixed tens-digit T-flip-flop counters. It adds configurable modulus, up/down counting, parallel load and a cascade carry. Instances are chained (units -> tens -> minutes ...) by wiring carry_out of one digit to carry_in of the next, all on the same clk.

Parameters:
MODULUS, 10, count range 0..MODULUS-1; legal 2..16 (6 for tens-of-seconds/minutes digits, 10 for units)
WIDTH, 4, digit width in bits; must satisfy 2^WIDTH >= MODULUS
RESET_VAL, 0, value loaded on reset; must be < MODULUS

Ports:
clk  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous active-low reset
en  input  1  global enable; 0 freezes the digit and forces carry_out=0
carry_in  input  1  count request from previous digit (tie 1 for first digit)
dir  input  1  0 = count up, 1 = count down
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
q  output  WIDTH  current digit value (q[WIDTH-1] is MSB)
carry_out  output  1  combinational cascade: count step this cycle wraps the digit
zero  output  1  registered flag, 1 when q == 0
load_err  output  1  registered one-cycle pulse: last load was clamped

Behaviour:
- Reset: clk is the only clock; clear is synchronous and active-low. On a rising edge with clear=0: q=RESET_VAL, zero=(RESET_VAL==0), load_err=0. clear has priority over everything.
- Priority per edge: clear > load > count > hold.
- Load (clear=1, load=1): q <= load_val if load_val < MODULUS. Otherwise q <= MODULUS-1 and load_err <= 1 for exactly one cycle. Load ignores en, carry_in and dir. carry_out=0 during a load cycle.
- Count (clear=1, load=0, en=1, carry_in=1):
  - Up: q <= (q == MODULUS-1) ? 0 : q+1.
  - Down: q <= (q == 0) ? MODULUS-1 : q-1.
- Hold: in all other cases q is unchanged and load_err <= 0.
- carry_out = en & carry_in & ~load & clear & ((dir==0 & q==MODULUS-1) | (dir==1 & q==0)). It is purely combinational so an N-digit chain steps in one cycle, with no ripple latency between digits.
- zero is registered: it is updated the same edge q changes and always equals (q==0) after that edge.
- Latency: q changes one edge after a qualified request. carry_out is valid in the same cycle as the request.
- Out-of-range q (only reachable by SEU/X): the next count edge forces q <= 0 (up) or MODULUS-1 (down). No lock-up.
- dir may change any cycle; the new dir applies on that edge.
- clear asserted mid-count discards any pending load/count that cycle.
- No internal state other than q, zero and load_err. No FSM beyond the counter itself.

Optional Feature:
Macro BCD_DIGIT_SEG7_EN.
- Defined: adds output seg (7 bits, {g,f,e,d,c,b,a}, active-high). It is registered from the next value of q, so seg always matches q with no extra latency. Values 10..15 decode to all-off. Reset value = decode(RESET_VAL).
- Undefined: no seg port and no decoder logic. All other behaviour is identical.

Test Plan:
- Reset: MODULUS=6, RESET_VAL=0, clear=0 for 2 edges then 1, en=0 -> q=0, zero=1, load_err=0, carry_out=0.
- Up wrap: MODULUS=6, en=1, carry_in=1, dir=0 for 7 edges from 0 -> q = 1,2,3,4,5,0,1. carry_out=1 only in the cycle q=5. zero=1 after the 6th edge.
- Down wrap: MODULUS=10, load 0, dir=1, 3 counts -> q = 9,8,7. carry_out=1 only in the cycle q=0.
- Load clamp: MODULUS=6, load=1, load_val=9 -> q=5 and load_err=1 for one cycle. load_val=3 next cycle -> q=3, load_err=0. Simultaneous load+count: load wins, carry_out=0.
- Cascade: units (MODULUS=10) -> tens (MODULUS=6), both counting up from 59 -> one edge later 00. The tens carry_out is high in the cycle before. Then clear=0 mid-sequence -> both digits at RESET_VAL next edge.
- BCD_DIGIT_SEG7_EN defined: q stepping 0..9 -> seg = 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F. Loading 12 with MODULUS=16 -> seg=0x00.

Source files
------------

// File: rtl/bcd_digit_counter.sv
// Single-digit modulo-N counter with load clamp and combinational cascade carry.
// Optional 7-segment output enabled by defining BCD_DIGIT_SEG7_EN.
module bcd_digit_counter #(
  parameter int MODULUS   = 10,
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             carry_in,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             zero,
`ifdef BCD_DIGIT_SEG7_EN
  output logic             load_err,
  output logic [6:0]       seg
`else
  output logic             load_err
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic             step;
  logic [WIDTH-1:0] nxt;
  logic             err_nxt;

  assign step = en & carry_in;

  assign carry_out = step & ~load & clear &
                     ((~dir & (q == MAX)) | (dir & (q == '0)));

  // Out-of-range q snaps back into range on the next count step.
  always_comb begin
    nxt     = q;
    err_nxt = 1'b0;
    unique case (1'b1)
      load: begin
        if (load_val > MAX) begin
          nxt     = MAX;
          err_nxt = 1'b1;
        end else begin
          nxt = load_val;
        end
      end
      ~load & step & ~dir: begin
        nxt = (q >= MAX) ? '0 : q + 1'b1;
      end
      ~load & step & dir: begin
        nxt = ((q == '0) || (q > MAX)) ? MAX : q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      q        <= RST;
      zero     <= (RST == '0);
      load_err <= 1'b0;
    end else begin
      q        <= nxt;
      zero     <= (nxt == '0);
      load_err <= err_nxt;
    end
  end

`ifdef BCD_DIGIT_SEG7_EN
  function automatic logic [6:0] seg7(input logic [WIDTH-1:0] v);
    int idx;
    idx = int'(v);
    case (idx)
      0:       seg7 = 7'h3F;
      1:       seg7 = 7'h06;
      2:       seg7 = 7'h5B;
      3:       seg7 = 7'h4F;
      4:       seg7 = 7'h66;
      5:       seg7 = 7'h6D;
      6:       seg7 = 7'h7D;
      7:       seg7 = 7'h07;
      8:       seg7 = 7'h7F;
      9:       seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Decoded from the next value so seg lines up with q on the same edge.
  always_ff @(posedge clk) begin
    if (!clear) seg <= seg7(RST);
    else        seg <= seg7(nxt);
  end
`endif

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Random and directed checks of bcd_digit_counter against a modulo-arithmetic model.
// Four digits: mod-6, mod-10 units driving mod-6 tens, and mod-16 with reset 3.
module tb_bcd_digit_counter;

  logic       clk = 1'b0;
  logic       clear, en, dir;
  logic [3:0] ld, cin;
  logic [3:0] lv [4];
  logic [3:0] q  [4];
  logic       co [4];
  logic       zr [4];
  logic       er [4];
  logic [6:0] sg [4];

  int n_pass = 0;
  int n_total = 0;

  int modv [4] = '{6, 10, 6, 16};
  int rstv [4] = '{0, 0, 0, 3};
  int mq   [4];
  bit merr [4];
  bit mco  [4];
  logic [6:0] segtab [16];

  always #5 clk = ~clk;

  bcd_digit_counter #(.MODULUS(6), .WIDTH(4), .RESET_VAL(0)) u_a (
    .clk(clk), .clear(clear), .en(en), .carry_in(cin[0]), .dir(dir),
    .load(ld[0]), .load_val(lv[0]), .q(q[0]), .carry_out(co[0]),
`ifdef BCD_DIGIT_SEG7_EN
    .zero(zr[0]), .load_err(er[0]), .seg(sg[0])
`else
    .zero(zr[0]), .load_err(er[0])
`endif
  );

  bcd_digit_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_units (
    .clk(clk), .clear(clear), .en(en), .carry_in(cin[1]), .dir(dir),
    .load(ld[1]), .load_val(lv[1]), .q(q[1]), .carry_out(co[1]),
`ifdef BCD_DIGIT_SEG7_EN
    .zero(zr[1]), .load_err(er[1]), .seg(sg[1])
`else
    .zero(zr[1]), .load_err(er[1])
`endif
  );

  bcd_digit_counter #(.MODULUS(6), .WIDTH(4), .RESET_VAL(0)) u_tens (
    .clk(clk), .clear(clear), .en(en), .carry_in(co[1]), .dir(dir),
    .load(ld[2]), .load_val(lv[2]), .q(q[2]), .carry_out(co[2]),
`ifdef BCD_DIGIT_SEG7_EN
    .zero(zr[2]), .load_err(er[2]), .seg(sg[2])
`else
    .zero(zr[2]), .load_err(er[2])
`endif
  );

  bcd_digit_counter #(.MODULUS(16), .WIDTH(4), .RESET_VAL(3)) u_hex (
    .clk(clk), .clear(clear), .en(en), .carry_in(cin[3]), .dir(dir),
    .load(ld[3]), .load_val(lv[3]), .q(q[3]), .carry_out(co[3]),
`ifdef BCD_DIGIT_SEG7_EN
    .zero(zr[3]), .load_err(er[3]), .seg(sg[3])
`else
    .zero(zr[3]), .load_err(er[3])
`endif
  );

`ifndef BCD_DIGIT_SEG7_EN
  initial for (int i = 0; i < 4; i++) sg[i] = '0;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit ci_of(int i);
    return (i == 2) ? mco[1] : cin[i];
  endfunction

  function automatic bit mcarry(int i);
    bit hit;
    hit = dir ? (mq[i] == 0) : (mq[i] == modv[i] - 1);
    return en && ci_of(i) && !ld[i] && clear && hit;
  endfunction

  // Model: plain modular arithmetic, clamp on oversize loads.
  task automatic mstep(int i, bit ci);
    int m;
    m = modv[i];
    merr[i] = 1'b0;
    if (!clear) begin
      mq[i] = rstv[i];
    end else if (ld[i]) begin
      if (int'(lv[i]) >= m) begin
        mq[i] = m - 1;
        merr[i] = 1'b1;
      end else begin
        mq[i] = int'(lv[i]);
      end
    end else if (en && ci) begin
      mq[i] = dir ? (mq[i] + m - 1) % m : (mq[i] + 1) % m;
    end
  endtask

  task automatic cycle();
    bit cis [4];
    #1;
    for (int i = 0; i < 4; i++) mco[i] = mcarry(i);
    for (int i = 0; i < 4; i++) begin
      cis[i] = ci_of(i);
      check($sformatf("carry_out[%0d]", i), co[i], mco[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) mstep(i, cis[i]);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q[%0d]", i), q[i], mq[i]);
      check($sformatf("zero[%0d]", i), zr[i], mq[i] == 0);
      check($sformatf("load_err[%0d]", i), er[i], merr[i]);
`ifdef BCD_DIGIT_SEG7_EN
      check($sformatf("seg[%0d]", i), sg[i], segtab[mq[i]]);
`endif
    end
  endtask

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    for (int i = 0; i < 4; i++) begin
      mq[i] = rstv[i];
      merr[i] = 1'b0;
      mco[i] = 1'b0;
      lv[i] = '0;
    end
    clear = 1'b0; en = 1'b0; dir = 1'b0; ld = '0; cin = '0;
    @(negedge clk);

    cycle(); cycle();
    check("reset_q", q[0], 0);
    check("reset_zero", zr[0], 1);
    check("reset_q_hex", q[3], 3);
    clear = 1'b1;
    cycle();

    en = 1'b1; cin[0] = 1'b1; dir = 1'b0;
    repeat (6) cycle();
    check("up_wrap_q6", q[0], 0);
    check("up_wrap_zero6", zr[0], 1);
    cycle();
    check("up_wrap_q7", q[0], 1);

    cin[0] = 1'b0;
    ld[1] = 1'b1; lv[1] = 4'd0;
    cycle();
    ld[1] = 1'b0; cin[1] = 1'b1; dir = 1'b1;
    repeat (3) cycle();
    check("down_wrap_q", q[1], 7);
    cin[1] = 1'b0;

    ld[0] = 1'b1; lv[0] = 4'd9;
    cycle();
    check("clamp_q", q[0], 5);
    check("clamp_err", er[0], 1);
    lv[0] = 4'd3;
    cycle();
    check("load_q", q[0], 3);
    check("load_err_clr", er[0], 0);
    cin[0] = 1'b1; lv[0] = 4'd2;
    cycle();
    check("load_wins_q", q[0], 2);
    ld[0] = 1'b0; cin[0] = 1'b0;

    dir = 1'b0;
    ld[1] = 1'b1; lv[1] = 4'd9;
    ld[2] = 1'b1; lv[2] = 4'd5;
    cycle();
    ld[1] = 1'b0; ld[2] = 1'b0; cin[1] = 1'b1;
    #1;
    check("cascade_tens_co", co[2], 1);
    cycle();
    check("cascade_units", q[1], 0);
    check("cascade_tens", q[2], 0);
    cycle();
    clear = 1'b0;
    cycle();
    check("clear_units", q[1], 0);
    check("clear_tens", q[2], 0);
    clear = 1'b1; cin[1] = 1'b0;

    ld[3] = 1'b1; lv[3] = 4'd12;
    cycle();
    check("hex_load12", q[3], 12);
    ld[3] = 1'b0;

    repeat (600) begin
      clear = ($urandom % 25) != 0;
      en    = ($urandom % 5) != 0;
      dir   = ($urandom % 3) == 0;
      for (int i = 0; i < 4; i++) begin
        ld[i]  = ($urandom % 8) == 0;
        lv[i]  = 4'($urandom % 16);
        cin[i] = ($urandom % 4) != 0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
